// File: rtl/io_pkg.sv
// Shared types and constants for the IO slot arbiter and its round-robin picker.
package io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StLatch
  } io_state_e;

  localparam logic [1:0] IO_SLOT_DEFAULT = 2'd3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational grant, registered last-winner pointer.
module rr_arb2
  import io_pkg::*;
(
  input  logic       clk_8,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q;

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_idx_o = ~last_q;
    end else if (req_i[REQ_B]) begin
      gnt_idx_o = REQ_B;
    end else begin
      gnt_idx_o = REQ_A;
    end
  end

  // Reset points at B so that A wins the first tie.
  always_ff @(posedge clk_8) begin
    if (reset) begin
      last_q <= REQ_B;
    end else if (update_i && gnt_valid_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/io_slot_arbiter.sv
// Grants one IO transfer per free IO bus slot to requester A or B and drives the RAM command.
module io_slot_arbiter
  import io_pkg::*;
#(
  parameter logic [1:0]  IO_SLOT = IO_SLOT_DEFAULT,
  parameter int unsigned ADDR_W  = 23
) (
  input  logic              clk_8,
  input  logic              reset,
  input  logic [1:0]        bus_cycle,
  input  logic              hold,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  input  logic [15:0]       ram_din,
  output logic              busy
);

  io_state_e         state_q;
  logic              win_q;
  logic              we_q;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dout_q;
  logic              busy_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [15:0]       a_rdata_q;
  logic [15:0]       b_rdata_q;

  logic [1:0]        req_vec;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  assign req_vec = {b_req, a_req};

  rr_arb2 u_rr_arb2 (
    .clk_8      (clk_8),
    .reset      (reset),
    .req_i      (req_vec),
    .update_i   (grant),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  always_comb begin
    grant = (state_q == StIdle) && (bus_cycle == IO_SLOT) && !hold && gnt_valid;
    if (gnt_idx == REQ_A) begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end else begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // ack and rdata update on the same edge so the requester sees them together.
  always_ff @(posedge clk_8) begin
    if (reset) begin
      state_q   <= StIdle;
      win_q     <= REQ_A;
      we_q      <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            win_q   <= gnt_idx;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            dout_q  <= sel_wdata;
            read_q  <= ~sel_we;
            write_q <= sel_we;
            busy_q  <= 1'b1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= StLatch;
        end
        StLatch: begin
          if (win_q == REQ_A) begin
            a_ack_q <= 1'b1;
            if (!we_q) a_rdata_q <= ram_din;
          end else begin
            b_ack_q <= 1'b1;
            if (!we_q) b_rdata_q <= ram_din;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign ram_read  = read_q;
  assign ram_write = write_q;
  assign ram_addr  = addr_q;
  assign ram_dout  = dout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_io_slot_arbiter.sv
// Randomized bench for io_slot_arbiter against a transaction-level model and a 16-word RAM.
module tb_io_slot_arbiter;

  localparam int         AW   = 23;
  localparam logic [1:0] SLOT = 2'd3;

  logic          clk_8 = 1'b0;
  logic          reset;
  logic [1:0]    bus_cycle;
  logic          hold;
  logic          a_ack, b_ack;
  logic [15:0]   a_rdata, b_rdata;
  logic          ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;
  logic [15:0]   ram_din;
  logic          busy;

  logic          r_req   [2];
  logic          r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [15:0]   r_wdata [2];

  always #5 clk_8 = ~clk_8;

  io_slot_arbiter #(
    .IO_SLOT(SLOT),
    .ADDR_W (AW)
  ) dut (
    .clk_8    (clk_8),
    .reset    (reset),
    .bus_cycle(bus_cycle),
    .hold     (hold),
    .a_req    (r_req[0]),
    .a_we     (r_we[0]),
    .a_addr   (r_addr[0]),
    .a_wdata  (r_wdata[0]),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (r_req[1]),
    .b_we     (r_we[1]),
    .b_addr   (r_addr[1]),
    .b_wdata  (r_wdata[1]),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .ram_read (ram_read),
    .ram_write(ram_write),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: age of the transfer in flight (-1 none), round-robin memory, expected outputs.
  int            m_age  = -1;
  int            m_last = 1;
  int            m_win  = 0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic          e_read  = 1'b0;
  logic          e_write = 1'b0;
  logic          e_busy  = 1'b0;
  logic [AW-1:0] e_addr  = '0;
  logic [15:0]   e_dout  = '0;
  logic [1:0]    e_ack   = '0;
  logic [15:0]   e_rdata [2];
  logic [15:0]   mm      [16];
  logic [15:0]   ram_mem [16];
  logic [15:0]   ram_pend;
  logic [1:0]    bc_at_edge;

  int            strobe_cnt = 0;
  logic [1:0]    first_bc   = '0;
  int            ack_cnt    = 0;
  logic [3:0]    ack_order  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bc_at_edge = bus_cycle;
    if (e_write) mm[e_addr[3:0]] = e_dout;
    if (reset) begin
      m_age  = -1;
      m_last = 1;
      {e_read, e_write, e_busy} = '0;
      e_addr = '0;
      e_dout = '0;
      e_ack  = '0;
      e_rdata[0] = '0;
      e_rdata[1] = '0;
    end else begin
      e_ack = '0;
      if (m_age == 1) begin
        if (!m_we) e_rdata[m_win] = mm[m_addr[3:0]];
        e_ack[m_win] = 1'b1;
        e_busy = 1'b0;
        m_age  = -1;
      end else if (m_age == 0) begin
        e_read  = 1'b0;
        e_write = 1'b0;
        m_age   = 1;
      end else if (bus_cycle == SLOT && !hold && (r_req[0] || r_req[1])) begin
        if (r_req[0] && r_req[1]) m_win = 1 - m_last;
        else m_win = r_req[0] ? 0 : 1;
        m_last  = m_win;
        m_we    = r_we[m_win];
        m_addr  = r_addr[m_win];
        e_addr  = m_addr;
        e_dout  = r_wdata[m_win];
        e_read  = !m_we;
        e_write = m_we;
        e_busy  = 1'b1;
        m_age   = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_8);
    model_edge();
    @(negedge clk_8);
    check_eq("ram_read", 32'(ram_read), 32'(e_read));
    check_eq("ram_write", 32'(ram_write), 32'(e_write));
    check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
    check_eq("ram_dout", 32'(ram_dout), 32'(e_dout));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("a_ack", 32'(a_ack), 32'(e_ack[0]));
    check_eq("b_ack", 32'(b_ack), 32'(e_ack[1]));
    check_eq("a_rdata", 32'(a_rdata), 32'(e_rdata[0]));
    check_eq("b_rdata", 32'(b_rdata), 32'(e_rdata[1]));
    // RAM: write lands now, read data appears on ram_din one cycle after the read strobe.
    if (ram_write) ram_mem[ram_addr[3:0]] = ram_dout;
    ram_din  = ram_pend;
    ram_pend = ram_read ? ram_mem[ram_addr[3:0]] : 16'($urandom);
    if (ram_read || ram_write) begin
      if (strobe_cnt == 0) first_bc = bc_at_edge;
      strobe_cnt++;
    end
    if (a_ack || b_ack) begin
      ack_cnt++;
      ack_order = {ack_order[2:0], b_ack};
    end
    bus_cycle = bus_cycle + 2'd1;
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] addr,
                         input logic [15:0] wdata);
    r_we[r]    = we;
    r_addr[r]  = addr;
    r_wdata[r] = wdata;
    r_req[r]   = 1'b1;
  endtask

  task automatic wait_ack(input int r, input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      cycle();
      if (e_ack[r]) done = 1'b1;
    end
    r_req[r] = 1'b0;
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic rand_drive();
    for (int r = 0; r < 2; r++) begin
      if (e_ack[r]) r_req[r] = 1'b0;
      if (m_age >= 0 && m_win == r) begin
        if ($urandom_range(7) == 0) r_req[r] = 1'b0;
      end else if (r_req[r]) begin
        if ($urandom_range(15) == 0) r_req[r] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        set_req(r, 1'($urandom), ($urandom_range(3) == 0) ? 23'h7FFFFF : AW'($urandom),
                16'($urandom));
      end
    end
    if ($urandom_range(9) == 0) hold = ~hold;
    if (reset) reset = 1'b0;
    else if ($urandom_range(299) == 0) reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mm[i]      = 16'(i * 16'h1111) ^ 16'h5A3C;
      ram_mem[i] = 16'(i * 16'h1111) ^ 16'h5A3C;
    end
    e_rdata[0] = '0;
    e_rdata[1] = '0;
    for (int r = 0; r < 2; r++) begin
      r_req[r] = 1'b0; r_we[r] = 1'b0; r_addr[r] = '0; r_wdata[r] = '0;
    end
    ram_din = '0; ram_pend = '0;
    reset = 1'b1; hold = 1'b0; bus_cycle = 2'd0;
    cycle();
    cycle();
    reset = 1'b0;

    // Write by A.
    strobe_cnt = 0;
    set_req(0, 1'b1, 23'h001000, 16'hBEEF);
    wait_ack(0, "t031_ack");
    check_eq("t031_mem", 32'(ram_mem[0]), 32'h0000BEEF);
    check_eq("t031_strobes", 32'(strobe_cnt), 32'd1);

    // Read by B at the top address.
    ram_mem[15] = 16'h1234;
    mm[15]      = 16'h1234;
    set_req(1, 1'b0, 23'h7FFFFF, 16'h0000);
    wait_ack(1, "t032_ack");
    check_eq("t032_rdata", 32'(b_rdata), 32'h00001234);

    // Both held: alternating grants starting with A.
    pulse_reset();
    ack_cnt = 0; ack_order = '0;
    set_req(0, 1'b1, 23'h000002, 16'hAAAA);
    set_req(1, 1'b1, 23'h000004, 16'hBBBB);
    for (int i = 0; i < 40 && ack_cnt < 4; i++) cycle();
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (8) cycle();
    check_eq("t033_acks", 32'(ack_cnt), 32'd4);
    check_eq("t033_order", 32'(ack_order), 32'b0101);

    // Hold blocks grants; grant follows release at the IO slot.
    hold = 1'b1;
    strobe_cnt = 0;
    set_req(0, 1'b0, 23'h000005, 16'h0000);
    repeat (8) cycle();
    check_eq("t034_held", 32'(strobe_cnt), 32'd0);
    hold = 1'b0;
    wait_ack(0, "t034_ack");
    check_eq("t034_slot", 32'(first_bc), 32'(SLOT));
    check_eq("t034_strobes", 32'(strobe_cnt), 32'd1);

    // Reset during ACCESS abandons the transfer.
    set_req(0, 1'b1, 23'h000003, 16'h3333);
    for (int i = 0; i < 8 && !e_write; i++) cycle();
    r_req[0] = 1'b0;
    pulse_reset();
    check_eq("t035_strobe", 32'(ram_write), 32'd0);
    ack_cnt = 0;
    repeat (6) cycle();
    check_eq("t035_noack", 32'(ack_cnt), 32'd0);
    set_req(0, 1'b1, 23'h000003, 16'h4444);
    wait_ack(0, "t035_again");

    // Request raised at bus_cycle 0 must wait for slot 3.
    pulse_reset();
    for (int i = 0; i < 4 && bus_cycle != 2'd0; i++) cycle();
    strobe_cnt = 0;
    set_req(0, 1'b0, 23'h000007, 16'h0000);
    wait_ack(0, "t036_ack");
    check_eq("t036_slot", 32'(first_bc), 32'(SLOT));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      rand_drive();
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0; reset = 1'b0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/io_slot_arbiter.md
IO_SLOT_ARBITER -- requirements
Module: io_slot_arbiter

Interface
REQ-001 Parameter IO_SLOT, default 2'd3: bus_cycle value owned by IO transfers.
REQ-002 Parameter ADDR_W, default 23: word address width.
REQ-003 Port clk_8  in  1: system clock; all logic on its rising edge.
REQ-004 Port reset  in  1: reset, synchronous, active-high; clock clk_8.
REQ-005 Port bus_cycle  in  2: current 4-phase memory slot, advancing once per clk_8.
REQ-006 Port hold  in  1: high = no new grants (CPU bus request active).
REQ-007 Ports a_req in 1, a_we in 1, a_addr in ADDR_W, a_wdata in 16: requester A (SPI upload path).
REQ-008 Ports a_ack out 1, a_rdata out 16: A completion pulse and read data.
REQ-009 Ports b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: requester B (floppy/HDD DMA), same widths and meaning as A.
REQ-010 Ports ram_read out 1, ram_write out 1, ram_addr out ADDR_W, ram_dout out 16: RAM command.
REQ-011 Port ram_din  in  16: RAM read data, valid in the cycle after ram_read.
REQ-012 Port busy  out  1: high whenever the FSM is not IDLE.

Function
REQ-013 FSM states IDLE, ACCESS, LATCH; one transfer in flight at most.
REQ-014 IDLE -> ACCESS when bus_cycle==IO_SLOT, hold==0 and a_req|b_req; else stay IDLE.
REQ-015 On that transition: winner's addr, we and wdata registered into ram_addr, ram_dout and internal we; ram_read=~we or ram_write=we asserted for exactly the ACCESS cycle.
REQ-016 ACCESS -> LATCH unconditionally; ram_read/ram_write deasserted.
REQ-017 LATCH: ram_din captured into winner's rdata when the transfer was a read (rdata unchanged on write); winner's ack pulses high one cycle; -> IDLE.
REQ-018 Latency: req sampled at slot edge N -> ram strobe at N+1 -> ack at N+2.
REQ-019 Arbitration round-robin: 1-bit last-winner pointer, reset to B so A wins first tie; the single requester wins when only one is active; pointer updated on every grant.
REQ-020 Requester holds req, we, addr, wdata stable until ack; req high in the cycle after ack counts as a new request.
REQ-021 Requests arriving outside IO_SLOT wait for the next IO_SLOT; no grant issued while busy, regardless of bus_cycle.
REQ-022 hold rising during ACCESS/LATCH does not abort the transfer; it only blocks the next grant.
REQ-023 req dropped before grant: no transfer, no ack; req dropped after grant: transfer completes and ack still pulses.
REQ-024 ram_addr and ram_dout retain last value while IDLE; ram_read and ram_write never high together.
REQ-025 Each ack is at most one cycle wide; a_ack and b_ack never high together.

Reset
REQ-026 reset high: FSM -> IDLE, ram_read=0, ram_write=0, a_ack=b_ack=0, busy=0, pointer=B, ram_addr=0, ram_dout=0, a_rdata=b_rdata=0.
REQ-027 reset mid-transfer: transfer abandoned, no ack; arbitration resumes at the first IO_SLOT after reset falls.

Structure
REQ-028 Shared package io_pkg: FSM state typedef, IO_SLOT default, requester-index constants REQ_A=0, REQ_B=1.
REQ-029 One sub-module rr_arb2: 2-input round-robin pick, combinational grant plus registered pointer.
REQ-030 No clock-domain crossing inside the block; requesters present clk_8-synchronous signals.

Verification
REQ-031 a_req=1, a_we=1, a_addr=0x001000, a_wdata=0xBEEF at IO_SLOT -> ram_write high one cycle with ram_addr=0x001000, ram_dout=0xBEEF; a_ack at +2.
REQ-032 b_req read of 0x7FFFFF, ram_din=0x1234 in LATCH -> ram_read one cycle, b_rdata=0x1234, b_ack one cycle.
REQ-033 a_req and b_req held continuously for 4 IO slots -> grants A,B,A,B; exactly 4 acks total.
REQ-034 hold=1 with a_req=1 for 2 slots, then hold=0 -> no strobes while held; grant at first IO_SLOT after release.
REQ-035 reset asserted during ACCESS -> strobes low next cycle, no ack; subsequent request completes normally.
REQ-036 a_req raised at bus_cycle=0 -> ram strobe in cycle after bus_cycle==3, never earlier.
